// File: rtl/rv32_run_monitor.sv
// ============================================================================
// Module      : rv32_run_monitor
// Description : Run-control and observation block for the RV32I 5-stage core.
//               It holds the core in reset, releases it, and then counts run
//               cycles, stall cycles and flush cycles. It captures the
//               writeback result on the first cycle halt is seen and stops
//               the run with a watchdog if halt never comes.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk, rst       clock; asynchronous active-high reset
//   start          single-cycle run request (accepted in IDLE/HALTED/TIMEOUT)
//   halt/stall/flush, wb_result   core status inputs
//   core_rst_n     active-low reset driven to the core
//   busy           high while in RESET or RUN
//   done           sticky flag: the run ended on halt
//   timed_out      sticky flag: the run ended on the watchdog
//   cycle_count/stall_count/flush_count   saturating RUN-phase counters
//   halt_result    wb_result sampled on the halt cycle
//   signature      (only with RUN_MON_SIGNATURE_EN) rotate-xor of wb_result
// Optional feature macro: RUN_MON_SIGNATURE_EN
// ============================================================================
`default_nettype none

module rv32_run_monitor #(
  parameter int CNT_W          = 32,
  parameter int TIMEOUT_CYCLES = 200,
  parameter int RST_CYCLES     = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             halt,
  input  logic             stall,
  input  logic             flush,
  input  logic [31:0]      wb_result,
  output logic             core_rst_n,
  output logic             busy,
  output logic             done,
  output logic             timed_out,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count,
  output logic [31:0]      halt_result
`ifdef RUN_MON_SIGNATURE_EN
  ,
  output logic [31:0]      signature
`endif
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RESET   = 3'd1,
    S_RUN     = 3'd2,
    S_HALTED  = 3'd3,
    S_TIMEOUT = 3'd4
  } state_t;

  localparam int               RST_W       = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RST_W-1:0] RST_LAST    = RST_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

  state_t             state_q, state_d;
  logic               core_rst_n_q, core_rst_n_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               timed_out_q, timed_out_d;
  logic               halt_q, halt_d;
  logic [RST_W-1:0]   rst_cnt_q, rst_cnt_d;
  logic [CNT_W-1:0]   cycle_q, cycle_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic [31:0]        halt_res_q, halt_res_d;
  logic [31:0]        sig_q, sig_d;

  logic [CNT_W-1:0]   cycle_inc;
  logic               halt_edge;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign cycle_inc = sat_inc(cycle_q);
  // halt_q is forced low during RESET, so a halt already high on the first
  // RUN cycle still registers as an edge.
  assign halt_edge = halt & ~halt_q;

  always_comb begin
    state_d      = state_q;
    core_rst_n_d = core_rst_n_q;
    busy_d       = busy_q;
    done_d       = done_q;
    timed_out_d  = timed_out_q;
    halt_d       = halt_q;
    rst_cnt_d    = rst_cnt_q;
    cycle_d      = cycle_q;
    stall_cnt_d  = stall_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    halt_res_d   = halt_res_q;
    sig_d        = sig_q;

    case (state_q)
      S_IDLE, S_HALTED, S_TIMEOUT: begin
        if (start) begin
          state_d      = S_RESET;
          core_rst_n_d = 1'b0;
          busy_d       = 1'b1;
          done_d       = 1'b0;
          timed_out_d  = 1'b0;
          halt_d       = 1'b0;
          rst_cnt_d    = '0;
          cycle_d      = '0;
          stall_cnt_d  = '0;
          flush_cnt_d  = '0;
          halt_res_d   = '0;
          sig_d        = '0;
        end
      end

      S_RESET: begin
        halt_d = 1'b0;
        if (rst_cnt_q == RST_LAST) begin
          // core_rst_n rises on this edge so it is high for the first RUN cycle
          state_d      = S_RUN;
          core_rst_n_d = 1'b1;
        end else begin
          rst_cnt_d = rst_cnt_q + RST_W'(1);
        end
      end

      S_RUN: begin
        cycle_d = cycle_inc;
        if (stall) stall_cnt_d = sat_inc(stall_cnt_q);
        if (flush) flush_cnt_d = sat_inc(flush_cnt_q);
        halt_d = halt;
        if (!stall) sig_d = {sig_q[30:0], sig_q[31]} ^ wb_result;

        // Halt takes priority over the watchdog on the same cycle.
        if (halt_edge) begin
          state_d    = S_HALTED;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          halt_res_d = wb_result;
        end else if (cycle_inc == TIMEOUT_VAL) begin
          state_d      = S_TIMEOUT;
          busy_d       = 1'b0;
          timed_out_d  = 1'b1;
          core_rst_n_d = 1'b0;
        end
      end

      default: begin
        state_d      = S_IDLE;
        core_rst_n_d = 1'b0;
        busy_d       = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      core_rst_n_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      timed_out_q  <= 1'b0;
      halt_q       <= 1'b0;
      rst_cnt_q    <= '0;
      cycle_q      <= '0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
      halt_res_q   <= '0;
      sig_q        <= '0;
    end else begin
      state_q      <= state_d;
      core_rst_n_q <= core_rst_n_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      timed_out_q  <= timed_out_d;
      halt_q       <= halt_d;
      rst_cnt_q    <= rst_cnt_d;
      cycle_q      <= cycle_d;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      halt_res_q   <= halt_res_d;
      sig_q        <= sig_d;
    end
  end

  assign core_rst_n  = core_rst_n_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign timed_out   = timed_out_q;
  assign cycle_count = cycle_q;
  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;
  assign halt_result = halt_res_q;

`ifdef RUN_MON_SIGNATURE_EN
  assign signature = sig_q;
`else
  logic unused_sig;
  assign unused_sig = ^sig_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rv32_run_monitor.sv
// ============================================================================
// Module      : tb_rv32_run_monitor
// Description : Self-checking bench for rv32_run_monitor. A per-cycle model
//               of the run pushes the expected end-of-run record into a
//               scoreboard queue when the ending stimulus is driven; the
//               record is popped and compared once the DUT ends the run.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rv32_run_monitor;

  localparam int CNT_W          = 32;
  localparam int TIMEOUT_CYCLES = 200;
  localparam int RST_CYCLES     = 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             halt = 1'b0;
  logic             stall = 1'b0;
  logic             flush = 1'b0;
  logic [31:0]      wb_result = '0;
  logic             core_rst_n, busy, done, timed_out;
  logic [CNT_W-1:0] cycle_count, stall_count, flush_count;
  logic [31:0]      halt_result;
`ifdef RUN_MON_SIGNATURE_EN
  logic [31:0]      signature;
`endif

  rv32_run_monitor #(
    .CNT_W(CNT_W), .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .RST_CYCLES(RST_CYCLES)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .halt(halt), .stall(stall),
    .flush(flush), .wb_result(wb_result), .core_rst_n(core_rst_n),
    .busy(busy), .done(done), .timed_out(timed_out),
    .cycle_count(cycle_count), .stall_count(stall_count),
    .flush_count(flush_count), .halt_result(halt_result)
`ifdef RUN_MON_SIGNATURE_EN
    , .signature(signature)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        done;
    logic        to;
    logic [31:0] cyc;
    logic [31:0] stl;
    logic [31:0] fls;
    logic [31:0] res;
    logic [31:0] sig;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;

  // Reference model of the current run
  logic [31:0] m_cyc, m_stl, m_fls, m_sig;
  bit          m_halt_prev, m_active;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic start_run();
    int n;
    halt = 1'b0; stall = 1'b0; flush = 1'b0; wb_result = '0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    m_cyc = '0; m_stl = '0; m_fls = '0; m_sig = '0;
    m_halt_prev = 1'b0; m_active = 1'b1;
    check("start_clr_cycle", cycle_count, 32'd0);
    check("start_clr_done", done, 1'b0);
    check("start_clr_to", timed_out, 1'b0);
    check("start_busy", busy, 1'b1);
    check("start_core_rst", core_rst_n, 1'b0);
    n = 0;
    while (!core_rst_n && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    check("rst_hold_cycles", n, RST_CYCLES);
  endtask

  task automatic run_cycle(input bit s, input bit f, input bit h,
                           input logic [31:0] wb, input bit st);
    exp_t e;
    stall = s; flush = f; halt = h; wb_result = wb; start = st;
    if (m_active) begin
      if (m_cyc != 32'hFFFF_FFFF) m_cyc++;
      if (s) m_stl++;
      if (f) m_fls++;
      if (!s) m_sig = {m_sig[30:0], m_sig[31]} ^ wb;
      if (h && !m_halt_prev) begin
        e = '{1'b1, 1'b0, m_cyc, m_stl, m_fls, wb, m_sig};
        sb_q.push_back(e);
        m_active = 1'b0;
      end else if (m_cyc == TIMEOUT_CYCLES) begin
        e = '{1'b0, 1'b1, m_cyc, m_stl, m_fls, 32'd0, m_sig};
        sb_q.push_back(e);
        m_active = 1'b0;
      end
      m_halt_prev = h;
    end
    @(posedge clk); #1;
    start = 1'b0;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("end_busy", busy, 1'b0);
      check("end_done", done, e.done);
      check("end_timed_out", timed_out, e.to);
      check("end_cycle_count", cycle_count, e.cyc);
      check("end_stall_count", stall_count, e.stl);
      check("end_flush_count", flush_count, e.fls);
      check("end_halt_result", halt_result, e.res);
      check("end_core_rst_n", core_rst_n, e.done);
`ifdef RUN_MON_SIGNATURE_EN
      check("end_signature", signature, e.sig);
`endif
    end else if (m_active) begin
      check("run_busy", busy, 1'b1);
      check("run_cycle_count", cycle_count, m_cyc);
    end
  endtask

  initial begin
    // Power-on reset values
    repeat (3) @(posedge clk);
    #1;
    check("por_core_rst_n", core_rst_n, 1'b0);
    check("por_busy", busy, 1'b0);
    check("por_done", done, 1'b0);
    check("por_halt_result", halt_result, 32'd0);
    rst = 1'b0;

    // Asynchronous reset in the middle of a run (cycle 10)
    start_run();
    for (int i = 0; i < 9; i++) run_cycle(0, 0, 0, 32'h0, 0);
    #2 rst = 1'b1;
    #1;
    check("arst_core_rst_n", core_rst_n, 1'b0);
    check("arst_cycle_count", cycle_count, 32'd0);
    check("arst_busy", busy, 1'b0);
    check("arst_done", done, 1'b0);
    check("arst_timed_out", timed_out, 1'b0);
    m_active = 1'b0;
    @(posedge clk); #1 rst = 1'b0;

    // Normal halt on the 37th RUN cycle
    start_run();
    for (int i = 0; i < 36; i++) run_cycle(0, 0, 0, 32'h0, 0);
    run_cycle(0, 0, 1, 32'h0000_002A, 0);
    // Counters stay frozen in HALTED
    run_cycle(1, 1, 0, 32'h0, 0);
    run_cycle(1, 1, 1, 32'h0, 0);
    check("halted_frozen_cycle", cycle_count, 32'd37);
    check("halted_frozen_stall", stall_count, 32'd0);
    check("halted_core_rst_n", core_rst_n, 1'b1);

    // Stall/flush counting plus an ignored start during RUN (restart from HALTED)
    start_run();
    for (int i = 0; i < 5; i++) run_cycle(1, 0, 0, 32'h0, 0);
    for (int i = 0; i < 2; i++) run_cycle(0, 1, 0, 32'h0, 0);
    run_cycle(1, 1, 0, 32'h0, 0);
    run_cycle(0, 0, 0, 32'h0, 1);
    check("start_ignored_busy", busy, 1'b1);
    run_cycle(0, 0, 1, 32'h0000_0055, 0);

    // Watchdog timeout after 200 RUN cycles
    start_run();
    for (int i = 0; i < TIMEOUT_CYCLES; i++) run_cycle(0, 0, 0, 32'h0, 0);
    run_cycle(0, 0, 0, 32'h0, 0);
    check("timeout_core_rst_held", core_rst_n, 1'b0);
    check("timeout_frozen_cycle", cycle_count, TIMEOUT_CYCLES);

    // Halt edge on the watchdog threshold cycle: halt wins
    start_run();
    for (int i = 0; i < TIMEOUT_CYCLES - 1; i++) run_cycle(0, 0, 0, 32'h0, 0);
    run_cycle(0, 0, 1, 32'h1234_5678, 0);

    // Signature pattern: 0x1 then 0x2 unstalled, halt with wb_result 0
    start_run();
    run_cycle(0, 0, 0, 32'h1, 0);
    run_cycle(0, 0, 0, 32'h2, 0);
    run_cycle(1, 0, 0, 32'hDEAD_BEEF, 0);
    run_cycle(0, 0, 1, 32'h0, 0);

    // Halt already high on the first RUN cycle counts as an edge
    start_run();
    run_cycle(0, 0, 1, 32'hCAFE_0001, 0);

    check("scoreboard_empty", sb_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rv32_run_monitor.md
Name: rv32_run_monitor

Overview:
Hardware run-control and observation block for the RV32I 5-stage system. It drives the core's active-low reset and consumes the core status outputs: flush, stall, halt and wb_result.
- Sequences a run: hold core in reset, release it, count cycles, stalls and flushes.
- Captures the writeback result at halt and enforces a watchdog timeout.
- Lets an SoC wrapper or on-chip test controller do, in RTL, what the system bench does around rv32_system_top.

Parameters:
CNT_W, 32, width of cycle/stall/flush counters
TIMEOUT_CYCLES, 200, RUN cycles allowed before watchdog fires (1..2^CNT_W-1)
RST_CYCLES, 1, cycles core_rst_n is held low after start (>=1)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
start  in  1  single-cycle request to begin a run
halt  in  1  core halt status
stall  in  1  core pipeline stall status
flush  in  1  core pipeline flush status
wb_result  in  32  core writeback result
core_rst_n  out  1  active-low reset to the core
busy  out  1  high in RESET or RUN
done  out  1  sticky: run ended by halt
timed_out  out  1  sticky: run ended by watchdog
cycle_count  out  CNT_W  RUN cycles elapsed
stall_count  out  CNT_W  RUN cycles with stall=1
flush_count  out  CNT_W  RUN cycles with flush=1
halt_result  out  32  wb_result sampled on the halt cycle

Behaviour:
- All outputs registered. On rst (async): state=IDLE, core_rst_n=0, busy=0, done=0, timed_out=0, all counts=0, halt_result=0, halt_q=0.
- States: IDLE, RESET, RUN, HALTED, TIMEOUT.
- IDLE: core_rst_n=0.
  - start=1 -> RESET.
  - On that edge, clear counters, done, timed_out, halt_result and the reset-hold counter.
- RESET: core_rst_n=0 for exactly RST_CYCLES cycles, then -> RUN. core_rst_n=1 from the first RUN cycle. halt_q forced 0.
- RUN, per edge:
  - cycle_count+1; stall_count+1 if stall; flush_count+1 if flush. All counters saturate at all-ones.
  - halt_q <= halt.
- RUN halt detection: halt & ~halt_q is a halt edge.
  - The halt-edge cycle is counted.
  - Same edge: halt_result<=wb_result, done<=1, -> HALTED.
  - halt already high on the first RUN cycle counts as an edge.
- RUN watchdog: if the incremented cycle_count == TIMEOUT_CYCLES and there is no halt edge that cycle: timed_out<=1, -> TIMEOUT.
- Halt edge and watchdog threshold on the same cycle: halt wins; done=1, timed_out=0.
- Latency: halt edge sampled at edge N -> done/halt_result visible after edge N.
- HALTED: core_rst_n stays 1 so core state remains observable. Counters frozen.
- TIMEOUT: core_rst_n=0 from the next cycle. Counters frozen.
- start=1 in HALTED/TIMEOUT -> restart exactly as from IDLE.
- start ignored in RESET and RUN.
- done and timed_out are mutually exclusive and stay set until the next accepted start or rst.
- rst mid-run: core_rst_n drops immediately (async); everything returns to reset values.

Optional Feature:
Macro RUN_MON_SIGNATURE_EN.
- Defined: adds output port signature (32), reset 0, cleared on accepted start.
  - Each RUN cycle with stall=0: signature <= {signature[30:0],signature[31]} ^ wb_result.
  - Frozen outside RUN; includes the halt cycle.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
1. Reset: assert rst mid-RUN at cycle 10 -> core_rst_n=0 same cycle; counts=0, done=0, timed_out=0, busy=0.
2. Normal halt (RST_CYCLES=1): start, halt rises on 37th RUN cycle with wb_result=0x0000002A -> done=1, cycle_count=37, halt_result=0x0000002A, timed_out=0, core_rst_n=1, busy=0.
3. Stall/flush: in RUN drive stall-only 5 cycles, flush-only 2 cycles, both 1 cycle, then halt -> stall_count=6, flush_count=3.
4. Timeout (TIMEOUT_CYCLES=200): halt held 0 -> after 200th RUN cycle timed_out=1, done=0, cycle_count=200, core_rst_n=0 next cycle.
5. Tie: halt edge on 200th RUN cycle -> done=1, timed_out=0, cycle_count=200.
6. Restart: start during RUN ignored (counts unaffected). start in HALTED -> counts cleared, core_rst_n low RST_CYCLES cycles, then new run. With RUN_MON_SIGNATURE_EN, wb_result 0x1,0x2 on two unstalled cycles -> signature=0x00000000.
